// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// rst_sequencer : debounced PLL-lock watcher releasing staggered domain resets
// Revision      : 1.0  initial parametrised release
// ============================================================================
module rst_sequencer #(
  parameter int C_NUM_DOMAINS  = 4,
  parameter int C_LOCK_FILTER  = 8,
  parameter int C_RST_SYNC_NUM = 25,
  parameter int C_STAGE_DELAY  = 16,
  parameter int C_STICKY_LOCK  = 1,
  parameter int C_CNT_WIDTH    = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_i,
  input  logic                     pll_lock_i,
  input  logic                     soft_rst_i,
  output logic [C_NUM_DOMAINS-1:0] rst_o,
  output logic                     ready_o,
  output logic [C_CNT_WIDTH-1:0]   lost_cnt_o,
  output logic [2:0]               state_o
);

  localparam int FILT_W  = $clog2(C_LOCK_FILTER + 1);
  localparam int HOLD_W  = $clog2(C_RST_SYNC_NUM + 1);
  localparam int STAGE_W = $clog2(C_STAGE_DELAY + 1);

  localparam logic [FILT_W-1:0]      FILT_LAST  = FILT_W'(C_LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(C_RST_SYNC_NUM - 1);
  localparam logic [STAGE_W-1:0]     STAGE_LAST = STAGE_W'(C_STAGE_DELAY - 1);
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE    = C_CNT_WIDTH'(1);
  localparam logic [FILT_W-1:0]      FILT_ONE   = FILT_W'(1);
  localparam logic [HOLD_W-1:0]      HOLD_ONE   = HOLD_W'(1);
  localparam logic [STAGE_W-1:0]     STAGE_ONE  = STAGE_W'(1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } state_t;

  state_t                   state;
  logic [2:0]               lock_sync;
  logic [FILT_W-1:0]        filt_cnt;
  logic [HOLD_W-1:0]        hold_cnt;
  logic [STAGE_W-1:0]       stage_cnt;
  logic                     powerup_locked;

  logic                     lock_s;
  logic                     lock_d;
  logic                     lock_loss;
  logic                     restart;
  logic [C_NUM_DOMAINS-1:0] rst_next;

  // lock_sync[1] is the synchronised lock; lock_sync[2] is its previous value
  assign lock_s    = lock_sync[1];
  assign lock_d    = lock_sync[2];
  assign lock_loss = lock_d & ~lock_s & powerup_locked;
  assign restart   = lock_loss && (C_STICKY_LOCK == 0) && (state != WAIT_LOCK);
  // Releases walk upward one domain at a time; all-zero means the last one went
  assign rst_next  = rst_o << 1;
  assign state_o   = state;

  always_ff @(posedge sys_clk or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state          <= WAIT_LOCK;
      lock_sync      <= '0;
      filt_cnt       <= '0;
      hold_cnt       <= '0;
      stage_cnt      <= '0;
      powerup_locked <= 1'b0;
      rst_o          <= '1;
      ready_o        <= 1'b0;
      lost_cnt_o     <= '0;
    end else begin
      lock_sync <= {lock_sync[1:0], pll_lock_i};

      if (lock_loss && (lost_cnt_o != CNT_MAX))
        lost_cnt_o <= lost_cnt_o + CNT_ONE;

      if (restart) begin
        state    <= WAIT_LOCK;
        rst_o    <= '1;
        ready_o  <= 1'b0;
        filt_cnt <= '0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (!lock_s) begin
              filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
              state          <= HOLD;
              powerup_locked <= 1'b1;
              hold_cnt       <= '0;
              filt_cnt       <= '0;
            end else begin
              filt_cnt <= filt_cnt + FILT_ONE;
            end
          end

          HOLD: begin
            if (soft_rst_i) begin
              hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
              stage_cnt <= '0;
              rst_o     <= rst_next;
              if (rst_next == '0) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_ONE;
            end
          end

          RELEASE: begin
            if (soft_rst_i) begin
              state    <= HOLD;
              rst_o    <= '1;
              hold_cnt <= '0;
            end else if (stage_cnt == STAGE_LAST) begin
              stage_cnt <= '0;
              rst_o     <= rst_next;
              if (rst_next == '0) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end
            end else begin
              stage_cnt <= stage_cnt + STAGE_ONE;
            end
          end

          RUN: begin
            if (soft_rst_i) begin
              state    <= HOLD;
              rst_o    <= '1;
              ready_o  <= 1'b0;
              hold_cnt <= '0;
            end
          end

          default: begin
            state    <= WAIT_LOCK;
            rst_o    <= '1;
            ready_o  <= 1'b0;
            filt_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rst_sequencer : directed bench for a sticky (2-bit counter) and a relock instance
// Revision         : 1.0  initial release
// ============================================================================
module tb_rst_sequencer;

  logic       clk;
  logic       rst_n;
  logic       pll_s, pll_r;
  logic       soft_s, soft_r;
  logic [3:0] rst_s, rst_r;
  logic       ready_s, ready_r;
  logic [1:0] cnt_s;
  logic [7:0] cnt_r;
  logic [2:0] st_s, st_r;

  int errors = 0;
  int checks = 0;
  int ecount = 0;

  rst_sequencer #(
    .C_NUM_DOMAINS(4), .C_LOCK_FILTER(8), .C_RST_SYNC_NUM(25),
    .C_STAGE_DELAY(16), .C_STICKY_LOCK(1), .C_CNT_WIDTH(2)
  ) dut_s (
    .sys_clk(clk), .sys_rst_i(rst_n), .pll_lock_i(pll_s), .soft_rst_i(soft_s),
    .rst_o(rst_s), .ready_o(ready_s), .lost_cnt_o(cnt_s), .state_o(st_s)
  );

  rst_sequencer #(
    .C_NUM_DOMAINS(4), .C_LOCK_FILTER(8), .C_RST_SYNC_NUM(25),
    .C_STAGE_DELAY(16), .C_STICKY_LOCK(0), .C_CNT_WIDTH(8)
  ) dut_r (
    .sys_clk(clk), .sys_rst_i(rst_n), .pll_lock_i(pll_r), .soft_rst_i(soft_r),
    .rst_o(rst_r), .ready_o(ready_r), .lost_cnt_o(cnt_r), .state_o(st_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, ecount, obs, exp);
    end
  endtask

  task automatic tick_to(input int k);
    while (ecount < k) begin
      @(posedge clk);
      #1;
      ecount++;
    end
  endtask

  task automatic chk_s(input string tag, input logic [3:0] er, input logic erdy, input logic [2:0] est);
    check({tag, "_s_rst"}, rst_s, er);
    check({tag, "_s_ready"}, ready_s, erdy);
    check({tag, "_s_state"}, st_s, est);
  endtask

  task automatic chk_r(input string tag, input logic [3:0] er, input logic erdy, input logic [2:0] est);
    check({tag, "_r_rst"}, rst_r, er);
    check({tag, "_r_ready"}, ready_r, erdy);
    check({tag, "_r_state"}, st_r, est);
  endtask

  initial begin
    rst_n = 1'b0; pll_s = 1'b0; pll_r = 1'b0; soft_s = 1'b0; soft_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_s("reset", 4'hf, 1'b0, 3'd0);
    chk_r("reset", 4'hf, 1'b0, 3'd0);
    check("reset_cnt_s", cnt_s, 2'd0);
    check("reset_cnt_r", cnt_r, 8'd0);

    // Power-up latency
    rst_n = 1'b1; pll_s = 1'b1; pll_r = 1'b1; ecount = 0;
    tick_to(9);   check("filt_pending", st_r, 3'd0);
    tick_to(10);  check("filt_accept", st_r, 3'd1);
    tick_to(34);  chk_r("hold_end", 4'hf, 1'b0, 3'd1); check("hold_end_s", rst_s, 4'hf);
    tick_to(35);  chk_r("rel0", 4'he, 1'b0, 3'd2);     chk_s("rel0", 4'he, 1'b0, 3'd2);
    tick_to(50);  check("pre_rel1", rst_r, 4'he);
    tick_to(51);  check("rel1", rst_r, 4'hc);
    tick_to(67);  check("rel2", rst_r, 4'h8);
    tick_to(82);  chk_r("pre_rel3", 4'h8, 1'b0, 3'd2);
    tick_to(83);  chk_r("rel3", 4'h0, 1'b1, 3'd3);     chk_s("rel3", 4'h0, 1'b1, 3'd3);
    check("run_cnt_r", cnt_r, 8'd0);

    // Soft reset from RUN
    tick_to(90);  soft_s = 1'b1; soft_r = 1'b1;
    tick_to(91);  soft_s = 1'b0; soft_r = 1'b0;
    chk_r("soft_run", 4'hf, 1'b0, 3'd1); chk_s("soft_run", 4'hf, 1'b0, 3'd1);
    tick_to(115); check("soft_hold_end", rst_r, 4'hf);
    tick_to(116); chk_r("soft_rel0", 4'he, 1'b0, 3'd2);
    tick_to(163); check("soft_pre_rel3", rst_r, 4'h8);
    tick_to(164); chk_r("soft_rel3", 4'h0, 1'b1, 3'd3); chk_s("soft_rel3", 4'h0, 1'b1, 3'd3);

    // Lock drop in RUN: relock instance restarts, sticky instance keeps running
    tick_to(170); pll_s = 1'b0; pll_r = 1'b0;
    tick_to(172); chk_r("drop_pre", 4'h0, 1'b1, 3'd3); check("drop_pre_cnt", cnt_r, 8'd0);
    tick_to(173);
    chk_r("drop", 4'hf, 1'b0, 3'd0); check("drop_cnt_r", cnt_r, 8'd1);
    chk_s("drop", 4'h0, 1'b1, 3'd3); check("drop_cnt_s", cnt_s, 2'd1);
    tick_to(180); pll_s = 1'b1; pll_r = 1'b1;
    tick_to(214); check("relock_hold", rst_r, 4'hf);
    tick_to(215); chk_r("relock_rel0", 4'he, 1'b0, 3'd2);
    tick_to(262); check("relock_pre_rel3", rst_r, 4'h8);
    tick_to(263); chk_r("relock_rel3", 4'h0, 1'b1, 3'd3);
    chk_s("relock", 4'h0, 1'b1, 3'd3); check("relock_cnt_r", cnt_r, 8'd1);

    // Sticky drops 2..5 on the 2-bit counter
    tick_to(265);
    for (int n = 2; n <= 5; n++) begin
      pll_s = 1'b0;
      tick_to(ecount + 4);
      check($sformatf("sat_cnt_%0d", n), cnt_s, (n > 3) ? 2'd3 : 2'(n));
      chk_s($sformatf("sat_%0d", n), 4'h0, 1'b1, 3'd3);
      pll_s = 1'b1;
      tick_to(ecount + 4);
    end

    // Soft reset during RELEASE; relock instance also loses lock on that edge
    tick_to(300); soft_s = 1'b1; soft_r = 1'b1;
    tick_to(301); soft_s = 1'b0; soft_r = 1'b0;
    tick_to(343); pll_r = 1'b0;
    tick_to(345); chk_s("mid_rel", 4'hc, 1'b0, 3'd2); chk_r("mid_rel", 4'hc, 1'b0, 3'd2);
    soft_s = 1'b1; soft_r = 1'b1;
    tick_to(346); soft_s = 1'b0; soft_r = 1'b0; pll_r = 1'b1;
    chk_s("soft_rel", 4'hf, 1'b0, 3'd1);
    chk_r("soft_loss", 4'hf, 1'b0, 3'd0); check("soft_loss_cnt", cnt_r, 8'd2);
    tick_to(370); check("soft_rel_hold", rst_s, 4'hf);
    tick_to(371); chk_s("soft_rel_rel0", 4'he, 1'b0, 3'd2);
    tick_to(385);
    chk_s("pre_sysrst", 4'he, 1'b0, 3'd2); chk_r("pre_sysrst", 4'he, 1'b0, 3'd2);
    check("pre_sysrst_cnt_s", cnt_s, 2'd3);

    // Asynchronous reset mid-RELEASE, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_s("async_rst", 4'hf, 1'b0, 3'd0); chk_r("async_rst", 4'hf, 1'b0, 3'd0);
    check("async_cnt_s", cnt_s, 2'd0); check("async_cnt_r", cnt_r, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; ecount = 0;
    tick_to(34);  check("re_hold_r", rst_r, 4'hf); check("re_hold_s", rst_s, 4'hf);
    tick_to(35);  chk_r("re_rel0", 4'he, 1'b0, 3'd2); chk_s("re_rel0", 4'he, 1'b0, 3'd2);
    tick_to(83);  chk_r("re_rel3", 4'h0, 1'b1, 3'd3); chk_s("re_rel3", 4'h0, 1'b1, 3'd3);

    // Lock glitch before acceptance: filter restarts, nothing counted
    rst_n = 1'b0; pll_s = 1'b0; pll_r = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; pll_s = 1'b1; pll_r = 1'b1; ecount = 0;
    tick_to(5);   pll_s = 1'b0; pll_r = 1'b0;
    tick_to(6);   pll_s = 1'b1; pll_r = 1'b1;
    tick_to(12);  check("glitch_filt_r", st_r, 3'd0); check("glitch_filt_s", st_s, 3'd0);
    tick_to(40);  check("glitch_hold_r", rst_r, 4'hf); check("glitch_hold_s", rst_s, 4'hf);
    tick_to(41);  chk_r("glitch_rel0", 4'he, 1'b0, 3'd2); chk_s("glitch_rel0", 4'he, 1'b0, 3'd2);
    check("glitch_cnt_r", cnt_r, 8'd0); check("glitch_cnt_s", cnt_s, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
